// File: rtl/disk_dev.sv
// Behavioural disk endpoint: SECTORS x 512-byte store, byte-strobed read stream
// with a preamble strobe, and a latency-modelled byte write handshake.
module disk_dev #(
    parameter int SECTORS = 16,
    parameter int GAP     = 2,
    parameter int WLAT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic [7:0]  dev_data_in,
    output logic        dev_reading,
    output logic        dev_read_done,
    input  logic [7:0]  dev_data_out,
    input  logic        dev_we,
    output logic        dev_writing,
    output logic        dev_write_done
);
    localparam int SW = $clog2(SECTORS);
    localparam int GW = $clog2(GAP + 1);
    localparam int LW = $clog2(WLAT + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [LW-1:0] WLAT_LAST = LW'(WLAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_GAP, R_STB} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_DONE, W_HOLD} wstate_t;

    logic [7:0] mem [SECTORS*512];

    rstate_t       r_state, r_next;
    wstate_t       w_state, w_next;
    logic [SW-1:0] sector;
    logic [8:0]    rcnt, rcnt_next;
    logic [8:0]    wcnt, wcnt_next;
    logic          pre, pre_next;
    logic [GW-1:0] gcnt, gcnt_next;
    logic [LW-1:0] lcnt, lcnt_next;
    logic          wbusy, bus_wr, sector_wr, start, capture;
    logic [8:0]    sector_pad;
    logic          unused_bits;

    assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:1]};

    assign wbusy      = (w_state != W_IDLE);
    assign bus_wr     = STB & WE;
    assign sector_wr  = bus_wr & ~ADDR[2] & ~dev_reading & ~wbusy;
    assign start      = bus_wr & ADDR[2] & DAT_I[0] & ~dev_reading & ~wbusy;
    assign capture    = (w_state == W_IDLE) & dev_we & ~dev_reading & ~rst;
    assign sector_pad = 9'(sector);

    assign ACK         = STB;
    assign DAT_O       = STB ? {dev_reading, wbusy, 5'b0, wcnt, 7'b0, sector_pad} : '0;
    assign dev_data_in = mem[{sector, rcnt}];

    always_ff @(posedge clk) begin
        if (capture)
            mem[{sector, wcnt}] <= dev_data_out;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sector <= '0;
        else if (sector_wr)
            sector <= DAT_I[SW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rcnt    <= '0;
            pre     <= 1'b0;
            gcnt    <= '0;
        end else begin
            r_state <= r_next;
            rcnt    <= rcnt_next;
            pre     <= pre_next;
            gcnt    <= gcnt_next;
        end
    end

    // The preamble strobe presents byte 0 without advancing rcnt.
    always_comb begin
        r_next        = r_state;
        rcnt_next     = rcnt;
        pre_next      = pre;
        gcnt_next     = gcnt;
        dev_reading   = 1'b1;
        dev_read_done = 1'b0;
        case (r_state)
            R_IDLE: begin
                dev_reading = 1'b0;
                if (start) begin
                    r_next    = R_GAP;
                    rcnt_next = '0;
                    pre_next  = 1'b1;
                    gcnt_next = '0;
                end
            end
            R_GAP: begin
                if (gcnt == GAP_LAST) begin
                    r_next    = R_STB;
                    gcnt_next = '0;
                end else begin
                    gcnt_next = gcnt + 1'b1;
                end
            end
            R_STB: begin
                dev_read_done = 1'b1;
                if (pre) begin
                    pre_next = 1'b0;
                    r_next   = R_GAP;
                end else if (rcnt == 9'd511) begin
                    r_next = R_IDLE;
                end else begin
                    rcnt_next = rcnt + 9'd1;
                    r_next    = R_GAP;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            wcnt    <= '0;
            lcnt    <= '0;
        end else begin
            w_state <= w_next;
            wcnt    <= wcnt_next;
            lcnt    <= lcnt_next;
        end
    end

    // W_HOLD swallows the controller's trailing offer after byte 511.
    always_comb begin
        w_next         = w_state;
        wcnt_next      = wcnt;
        lcnt_next      = lcnt;
        dev_writing    = 1'b0;
        dev_write_done = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (dev_we && !dev_reading) begin
                    w_next    = W_BUSY;
                    lcnt_next = '0;
                end
            end
            W_BUSY: begin
                dev_writing = 1'b1;
                if (lcnt == WLAT_LAST) begin
                    w_next    = W_DONE;
                    lcnt_next = '0;
                end else begin
                    lcnt_next = lcnt + 1'b1;
                end
            end
            W_DONE: begin
                dev_writing    = 1'b1;
                dev_write_done = 1'b1;
                if (wcnt == 9'd511) begin
                    wcnt_next = '0;
                    w_next    = W_HOLD;
                end else begin
                    wcnt_next = wcnt + 9'd1;
                    w_next    = W_IDLE;
                end
            end
            W_HOLD: begin
                if (!dev_we)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_disk_dev.sv
// Scoreboard bench for disk_dev: sectors written through the byte handshake,
// then read back through strobe streams and compared against a bench memory model.
module tb_disk_dev;
    localparam int SECTORS = 16;
    localparam int GAP     = 2;
    localparam int WLAT    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        STB, WE;
    logic [31:0] ADDR, DAT_I, DAT_O;
    logic        ACK;
    logic [7:0]  dev_data_in, dev_data_out;
    logic        dev_reading, dev_read_done, dev_we, dev_writing, dev_write_done;

    int tests  = 0;
    int errors = 0;
    logic [7:0] model_mem [SECTORS*512];
    logic [7:0] sb [$];

    disk_dev #(.SECTORS(SECTORS), .GAP(GAP), .WLAT(WLAT)) dut (
        .clk(clk), .rst(rst), .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
        .DAT_O(DAT_O), .ACK(ACK), .dev_data_in(dev_data_in), .dev_reading(dev_reading),
        .dev_read_done(dev_read_done), .dev_data_out(dev_data_out), .dev_we(dev_we),
        .dev_writing(dev_writing), .dev_write_done(dev_write_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] status(input logic rd, input logic wb,
                                           input logic [8:0] wc, input logic [8:0] sec);
        return {rd, wb, 5'b0, wc, 7'b0, sec};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1; STB = 1'b1; WE = 1'b1; ADDR = a; DAT_I = d;
        @(negedge clk); check("bus_ack", {31'b0, ACK}, 32'd1);
        @(posedge clk); #1; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
    endtask

    task automatic status_check(input string tag, input logic [31:0] exp);
        @(posedge clk); #1; STB = 1'b1; WE = 1'b0; ADDR = '0;
        @(negedge clk); check(tag, DAT_O, exp);
        @(posedge clk); #1; STB = 1'b0;
    endtask

    task automatic write_sector(input int s, input bit inv, input bit conflict);
        int cyc, last, waited;
        bus_write(32'h0, 32'(s));
        for (int i = 0; i < 512; i++)
            model_mem[s*512 + i] = inv ? 8'(255 - i) : 8'(i);
        @(posedge clk); #1; dev_we = 1'b1; dev_data_out = model_mem[s*512];
        cyc = 0; last = 0;
        for (int i = 0; i < 512; i++) begin
            waited = 0;
            do begin
                @(negedge clk); cyc++; waited++;
            end while (!dev_write_done && waited < 4*WLAT + 10);
            check("wr_done", {31'b0, dev_write_done}, 32'd1);
            check("wr_writing", {31'b0, dev_writing}, 32'd1);
            check("wr_period", 32'(cyc - last), 32'(WLAT + 2));
            last = cyc;
            @(posedge clk); #1;
            dev_data_out = (i == 511) ? model_mem[s*512] : model_mem[s*512 + i + 1];
        end
        @(negedge clk);
        check("hold_done", {31'b0, dev_write_done}, 32'd0);
        check("hold_writing", {31'b0, dev_writing}, 32'd0);
        if (conflict) begin
            bus_write(32'h0, 32'd7);
            bus_write(32'h4, 32'd1);
            @(negedge clk);
            check("hold_no_start", {31'b0, dev_reading}, 32'd0);
        end
        status_check("hold_status", status(1'b0, 1'b1, 9'd0, 9'(s)));
        @(posedge clk); #1; dev_we = 1'b0;
        @(posedge clk); #1;
        status_check("rearm_status", status(1'b0, 1'b0, 9'd0, 9'(s)));
    endtask

    task automatic read_stream(input int s, input int abort_at);
        int c, k;
        logic [7:0] e;
        sb.delete();
        for (int j = 0; j < 513; j++)
            sb.push_back(model_mem[s*512 + ((j == 0) ? 0 : j - 1)]);
        @(posedge clk); #1; STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'd1;
        @(posedge clk); #1; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
        c = 0; k = 0;
        while (c < 1545) begin
            @(negedge clk); c++;
            if (c == 1) check("rd_active", {31'b0, dev_reading}, 32'd1);
            if (dev_read_done) begin
                check("rd_time", 32'(c), 32'((k + 1) * (GAP + 1)));
                if (sb.size() == 0) begin
                    check("rd_extra", 32'(k), 32'd512);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", {24'b0, dev_data_in}, {24'b0, e});
                end
                if (k == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rst_mid_reading", {31'b0, dev_reading}, 32'd0);
                    check("rst_mid_strobe", {31'b0, dev_read_done}, 32'd0);
                    rst = 1'b0;
                    sb.delete();
                    return;
                end
                k++;
            end
            if (c == 20) begin
                STB = 1'b1; WE = 1'b1; ADDR = '0; DAT_I = 32'd9;
                dev_we = 1'b1; dev_data_out = 8'hAA;
            end
            if (c == 21) begin STB = 1'b0; WE = 1'b0; DAT_I = '0; end
            if (c == 30) dev_we = 1'b0;
            if (c == 39) begin STB = 1'b1; WE = 1'b0; end
            if (c == 40) begin
                check("rd_status", DAT_O, status(1'b1, 1'b0, 9'd0, 9'(s)));
                STB = 1'b0;
            end
            if (c == 1540) begin
                check("rd_end", {31'b0, dev_reading}, 32'd0);
                check("rd_count", 32'(k), 32'd513);
                c = 2000;
            end
        end
        if (c != 2000) check("rd_timeout", 32'(c), 32'd1540);
    endtask

    initial begin
        rst = 1'b1; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
        dev_we = 1'b1; dev_data_out = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_reading", {31'b0, dev_reading}, 32'd0);
        check("rst_read_done", {31'b0, dev_read_done}, 32'd0);
        check("rst_writing", {31'b0, dev_writing}, 32'd0);
        check("rst_write_done", {31'b0, dev_write_done}, 32'd0);
        check("rst_dat_o_idle", DAT_O, 32'd0);
        check("rst_ack_idle", {31'b0, ACK}, 32'd0);
        STB = 1'b1; #1;
        check("rst_ack", {31'b0, ACK}, 32'd1);
        check("rst_status", DAT_O, 32'd0);
        @(posedge clk); #1; rst = 1'b0; dev_we = 1'b0; STB = 1'b0;
        status_check("post_rst_status", 32'd0);

        write_sector(3, 1'b0, 1'b0);
        write_sector(5, 1'b1, 1'b1);
        bus_write(32'h0, 32'd3);
        read_stream(3, -1);
        bus_write(32'h0, 32'd5);
        read_stream(5, -1);
        bus_write(32'h0, 32'd3);
        read_stream(3, 100);
        status_check("post_abort_status", 32'd0);
        bus_write(32'h0, 32'd3);
        read_stream(3, -1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
